// File: rtl/imm_pkg.sv
// Shared definitions for the RV32I immediate encoder: format selects,
// instruction immediate-field bit positions, the stage-1 payload and
// small helpers used by the packer.
package imm_pkg;

  // Format select as carried on in_extop; codes above EXT_J alias to J.
  typedef enum logic [2:0] {
    EXT_I = 3'b000,
    EXT_U = 3'b001,
    EXT_S = 3'b010,
    EXT_B = 3'b011,
    EXT_J = 3'b100
  } ext_e;

  // Immediate-field positions inside the 32-bit instruction word.
  localparam int I_IMM_LSB  = 20;  // I: [31:20]
  localparam int U_IMM_LSB  = 12;  // U: [31:12]
  localparam int S_HI_LSB   = 25;  // S/B: [31:25] high part
  localparam int S_LO_LSB   = 7;   // S: [11:7] low part
  localparam int B_LO_LSB   = 8;   // B: [11:8] = imm[4:1]
  localparam int B_B11_BIT  = 7;   // B: [7] = imm[11]
  localparam int SIGN_BIT   = 31;  // B/J: sign bit of the immediate
  localparam int J_LO_LSB   = 21;  // J: [30:21] = imm[10:1]
  localparam int J_B11_BIT  = 20;  // J: [20] = imm[11]
  localparam int J_MID_LSB  = 12;  // J: [19:12] = imm[19:12]

  // Request captured by stage 1 and consumed by stage 2.
  typedef struct packed {
    logic [2:0]  extop;
    logic [31:0] imm;
    logic [31:0] tmpl;
  } s1_payload_t;

  // Map the raw 3-bit select onto a format; 100..111 all mean J.
  function automatic ext_e ext_decode(input logic [2:0] raw);
    return (raw > 3'b011) ? EXT_J : ext_e'(raw);
  endfunction

  // True when imm[31:msb] are all equal, i.e. imm fits a signed field
  // whose sign bit sits at position msb.
  function automatic logic sext_fits(input logic [31:0] imm, input int msb);
    logic [31:0] top;
    top = $signed(imm) >>> msb;
    return (top == '0) || (top == '1);
  endfunction

endpackage

// File: rtl/imm_field_pack.sv
// Combinational packer: writes a 32-bit immediate into the immediate
// fields of an RV32I instruction template and flags immediates that the
// selected format cannot represent. Non-immediate template bits pass
// through untouched; on error the truncated encoding is still produced.
module imm_field_pack
  import imm_pkg::*;
(
  input  logic [2:0]  extop,
  input  logic [31:0] imm,
  input  logic [31:0] tmpl,
  output logic [31:0] instr,
  output logic        err
);

  // Overwrite the immediate fields of the selected format and range-check.
  always_comb begin
    // NOTE: default every output first so no path through the case can
    // leave a value unassigned and infer a latch.
    instr = tmpl;
    err   = 1'b0;
    case (ext_decode(extop))
      EXT_I: begin
        instr[I_IMM_LSB +: 12] = imm[11:0];
        err                    = !sext_fits(imm, 11);
      end
      EXT_U: begin
        instr[U_IMM_LSB +: 20] = imm[31:12];
        err                    = (imm[11:0] != 12'h000);
      end
      EXT_S: begin
        instr[S_HI_LSB +: 7]   = imm[11:5];
        instr[S_LO_LSB +: 5]   = imm[4:0];
        err                    = !sext_fits(imm, 11);
      end
      EXT_B: begin
        instr[SIGN_BIT]        = imm[12];
        instr[S_HI_LSB +: 6]   = imm[10:5];
        instr[B_LO_LSB +: 4]   = imm[4:1];
        instr[B_B11_BIT]       = imm[11];
        err                    = !sext_fits(imm, 12) || imm[0];
      end
      default: begin
        instr[SIGN_BIT]        = imm[20];
        instr[J_LO_LSB +: 10]  = imm[10:1];
        instr[J_B11_BIT]       = imm[11];
        instr[J_MID_LSB +: 8]  = imm[19:12];
        err                    = !sext_fits(imm, 20) || imm[0];
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// RV32I immediate encoder: two-stage valid/ready pipeline that packs a
// 32-bit immediate into an instruction template, flags unrepresentable
// immediates and keeps saturating handoff/error counters.
// Stage 1 registers the request; stage 2 packs, range-checks and
// registers the result. Full throughput with out_ready held high.
// Optional build macro IMM_ENCODER_ROUNDTRIP_EN adds a registered
// rt_mismatch flag that decodes each result back and compares it with
// the original immediate.
module imm_encoder
  import imm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_extop,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      in_tmpl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
`ifdef IMM_ENCODER_ROUNDTRIP_EN
  output logic             rt_mismatch,
`endif
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  logic        v1;
  s1_payload_t d1;
  logic        adv1;
  logic        adv2;
  logic        fire;
  logic [31:0] pack_instr;
  logic        pack_err;

  // Each stage moves when it is empty or its downstream is moving.
  assign adv2     = !out_valid || out_ready;
  assign adv1     = !v1 || adv2;
  assign in_ready = adv1;
  assign fire     = out_valid && out_ready;

  // Stage 1 valid bit: loads whenever the stage advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
    end else if (adv1) begin
      v1 <= in_valid;
    end
  end

  // Stage 1 payload: captured on accept.
  // NOTE: the payload is deliberately not reset; it is only observed
  // while v1 is set, so clearing it would add reset fan-out for nothing.
  always_ff @(posedge clk) begin
    if (adv1 && in_valid) begin
      d1 <= '{extop: in_extop, imm: in_imm, tmpl: in_tmpl};
    end
  end

  imm_field_pack u_pack (
    .extop (d1.extop),
    .imm   (d1.imm),
    .tmpl  (d1.tmpl),
    .instr (pack_instr),
    .err   (pack_err)
  );

  // Stage 2: register the packed result; holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
    end else if (adv2) begin
      out_valid <= v1;
      if (v1) begin
        out_instr <= pack_instr;
        out_err   <= pack_err;
      end
    end
  end

  // Saturating statistics counted on each output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      enc_count <= '0;
      err_count <= '0;
    end else if (fire) begin
      if (enc_count != '1) begin
        enc_count <= enc_count + CNT_W'(1);
      end
      if (out_err && (err_count != '1)) begin
        err_count <= err_count + CNT_W'(1);
      end
    end
  end

`ifdef IMM_ENCODER_ROUNDTRIP_EN
  logic [31:0] rt_imm;

  // Decode the packed word back to a sign-extended immediate.
  always_comb begin
    rt_imm = '0;
    case (ext_decode(d1.extop))
      EXT_I:   rt_imm = {{20{pack_instr[31]}}, pack_instr[31:20]};
      EXT_U:   rt_imm = {pack_instr[31:12], 12'h000};
      EXT_S:   rt_imm = {{20{pack_instr[31]}}, pack_instr[31:25], pack_instr[11:7]};
      EXT_B:   rt_imm = {{19{pack_instr[31]}}, pack_instr[31], pack_instr[7],
                         pack_instr[30:25], pack_instr[11:8], 1'b0};
      default: rt_imm = {{11{pack_instr[31]}}, pack_instr[31], pack_instr[19:12],
                         pack_instr[20], pack_instr[30:21], 1'b0};
    endcase
  end

  // Flag a valid, in-range result whose decoded immediate disagrees.
  always_ff @(posedge clk) begin
    if (rst) begin
      rt_mismatch <= 1'b0;
    end else if (adv2) begin
      rt_mismatch <= v1 && !pack_err && (rt_imm != d1.imm);
    end
  end
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed vectors, throughput,
// backpressure, reset flush and a random mix, scored through a queue.
module tb_imm_encoder;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_extop;
  logic [31:0]      in_imm;
  logic [31:0]      in_tmpl;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             out_err;
  logic [CNT_W-1:0] enc_count;
  logic [CNT_W-1:0] err_count;
`ifdef IMM_ENCODER_ROUNDTRIP_EN
  logic             rt_mismatch;
`endif

  imm_encoder #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_extop  (in_extop),
    .in_imm    (in_imm),
    .in_tmpl   (in_tmpl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
`ifdef IMM_ENCODER_ROUNDTRIP_EN
    .rt_mismatch (rt_mismatch),
`endif
    .enc_count (enc_count),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_enc = 0;
  int          exp_err = 0;
  logic [31:0] cur_exp_instr;
  logic        cur_exp_err;
  bit          hold_chk = 0;
  logic [31:0] held_instr;
  logic        held_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference encoding built from masks and shifts.
  function automatic logic [31:0] m_enc(input logic [2:0] op, input logic [31:0] i,
                                        input logic [31:0] t);
    case (op)
      3'd0: return (t & 32'h000F_FFFF) | (i << 20);
      3'd1: return (t & 32'h0000_0FFF) | (i & 32'hFFFF_F000);
      3'd2: return (t & 32'h01FF_F07F) | (((i >> 5) & 32'h7F) << 25) | ((i & 32'h1F) << 7);
      3'd3: return (t & 32'h01FF_F07F) | (((i >> 12) & 32'h1) << 31)
                 | (((i >> 5) & 32'h3F) << 25) | (((i >> 1) & 32'hF) << 8)
                 | (((i >> 11) & 32'h1) << 7);
      default: return (t & 32'h0000_0FFF) | (((i >> 20) & 32'h1) << 31)
                 | (((i >> 1) & 32'h3FF) << 21) | (((i >> 11) & 32'h1) << 20)
                 | (i & 32'h000F_F000);
    endcase
  endfunction

  // Reference range check expressed as signed numeric bounds.
  function automatic logic m_err(input logic [2:0] op, input logic [31:0] i);
    int s;
    s = $signed(i);
    case (op)
      3'd0, 3'd2: return !(s >= -2048 && s <= 2047);
      3'd1:       return (i & 32'h0000_0FFF) != 0;
      3'd3:       return !(s >= -4096 && s <= 4095) || i[0];
      default:    return !(s >= -1048576 && s <= 1048575) || i[0];
    endcase
  endfunction

  // One clock: score handshakes seen before the edge, then advance.
  task automatic tick(output bit acc);
    exp_t e;
    #1;
    acc = 0;
    if (!rst) begin
      if (hold_chk) begin
        check("hold_instr", out_instr, held_instr);
        check("hold_err", {31'b0, out_err}, {31'b0, held_err});
      end
`ifdef IMM_ENCODER_ROUNDTRIP_EN
      if (out_valid) check("rt_mismatch", {31'b0, rt_mismatch}, 32'd0);
`endif
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_out", {31'b0, out_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("instr", out_instr, e.instr);
          check("err", {31'b0, out_err}, {31'b0, e.err});
          if (exp_enc < (1 << CNT_W) - 1) exp_enc++;
          if (e.err && exp_err < (1 << CNT_W) - 1) exp_err++;
        end
      end
      hold_chk   = out_valid && !out_ready;
      held_instr = out_instr;
      held_err   = out_err;
      if (in_valid && in_ready) begin
        sb.push_back('{instr: cur_exp_instr, err: cur_exp_err});
        acc = 1;
      end
    end else begin
      hold_chk = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input logic [2:0] op, input logic [31:0] imm, input logic [31:0] tmpl,
                         input logic [31:0] ei, input logic ee);
    in_valid      = 1'b1;
    in_extop      = op;
    in_imm        = imm;
    in_tmpl       = tmpl;
    cur_exp_instr = ei;
    cur_exp_err   = ee;
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] imm, input logic [31:0] tmpl,
                      input logic [31:0] ei, input logic ee);
    bit acc;
    acc = 0;
    set_req(op, imm, tmpl, ei, ee);
    for (int k = 0; k < 20; k++) begin
      tick(acc);
      if (acc) break;
    end
    if (!acc) check("send_timeout", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [2:0] op, input logic [31:0] imm, input logic [31:0] tmpl);
    send(op, imm, tmpl, m_enc(op, imm, tmpl), m_err(op, imm));
  endtask

  task automatic drain();
    bit acc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (sb.size() == 0 && !out_valid) break;
      tick(acc);
    end
    check("drain_left", sb.size(), 32'd0);
  endtask

  function automatic logic [31:0] rand_imm();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0:       return r;
      1:       return {{20{r[11]}}, r[11:0]};
      2:       return {{19{r[12]}}, r[12:1], 1'b0};
      3:       return {{11{r[20]}}, r[20:1], 1'b0};
      default: return r & 32'hFFFF_F000;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc;
    logic [2:0]  op;
    logic [31:0] im;
    logic [31:0] tm;

    rst = 1'b1; in_valid = 1'b0; in_extop = '0; in_imm = '0; in_tmpl = '0; out_ready = 1'b0;
    cur_exp_instr = '0; cur_exp_err = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_err", {31'b0, out_err}, 32'd0);
    check("rst_enc", {16'b0, enc_count}, 32'd0);
    check("rst_err", {16'b0, err_count}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // I-type with latency check.
    out_ready = 1'b1;
    send(3'b000, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0);
    check("lat_i_early", {31'b0, out_valid}, 32'd0);
    tick(acc);
    check("lat_i_valid", {31'b0, out_valid}, 32'd1);
    check("lat_i_instr", out_instr, 32'hFFF0_0013);
    tick(acc);
    check("enc_after_i", {16'b0, enc_count}, 32'd1);

    // Directed formats and range errors.
    send(3'b011, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0);
    send(3'b001, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 1'b0);
    send(3'b001, 32'h1234_5001, 32'h0000_0037, 32'h1234_5037, 1'b1);
    drain();
    check("err_after_u", {16'b0, err_count}, 32'd1);
    send(3'b100, 32'h0000_0003, 32'h0000_006F, 32'h0020_006F, 1'b1);
    send(3'b010, 32'h0000_0800, 32'h0000_0023, 32'h8000_0023, 1'b1);
    send(3'b111, 32'h000F_FFFE, 32'h0000_00EF, 32'h7FFF_F0EF, 1'b0);
    send(3'b101, 32'hFFF0_0000, 32'h0000_006F, 32'h8000_006F, 1'b0);
    send(3'b010, 32'hFFFF_F800, 32'hABCD_E0A3, 32'h81CD_E023 | 32'h0000_0080 & 32'h0, 1'b0);
    drain();
    check("enc_directed", {16'b0, enc_count}, exp_enc);
    check("err_directed", {16'b0, err_count}, exp_err);

    // Back-to-back throughput: one accept per cycle with out_ready high.
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      op = 3'($urandom_range(0, 7)); im = rand_imm(); tm = $urandom;
      set_req(op, im, tm, m_enc(op, im, tm), m_err(op, im));
      tick(acc);
      check("thru_accept", {31'b0, acc}, 32'd1);
    end
    drain();

    // Backpressure: two accepts fill the pipe, then stall and release.
    out_ready = 1'b0;
    send_m(3'b000, 32'h0000_0123, 32'h0000_0093);
    send_m(3'b001, 32'hABCD_E000, 32'h0000_02B7);
    set_req(3'b010, 32'h0000_07FF, 32'h0000_2023, m_enc(3'b010, 32'h0000_07FF, 32'h0000_2023),
            m_err(3'b010, 32'h0000_07FF));
    #1;
    check("bp_in_ready", {31'b0, in_ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick(acc);
      check("bp_no_accept", {31'b0, acc}, 32'd0);
    end
    out_ready = 1'b1;
    send_m(3'b010, 32'h0000_07FF, 32'h0000_2023);
    send_m(3'b011, 32'h0000_0FFE, 32'h0000_1063);
    drain();
    check("bp_enc", {16'b0, enc_count}, exp_enc);

    // Random mix with random backpressure.
    acc = 0;
    for (int c = 0; c < 80; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        op = 3'($urandom_range(0, 7)); im = rand_imm(); tm = $urandom;
        set_req(op, im, tm, m_enc(op, im, tm), m_err(op, im));
      end
      tick(acc);
      if (acc) in_valid = 1'b0;
    end
    drain();
    check("rand_enc", {16'b0, enc_count}, exp_enc);
    check("rand_err", {16'b0, err_count}, exp_err);

    // Reset with both stages full flushes everything.
    out_ready = 1'b0;
    send_m(3'b000, 32'h0000_0555, 32'h0000_0013);
    send_m(3'b001, 32'h5555_5000, 32'h0000_0037);
    rst = 1'b1;
    tick(acc);
    rst = 1'b0;
    sb.delete();
    exp_enc = 0;
    exp_err = 0;
    #1;
    check("flush_valid", {31'b0, out_valid}, 32'd0);
    check("flush_enc", {16'b0, enc_count}, 32'd0);
    check("flush_err", {16'b0, err_count}, 32'd0);
    out_ready = 1'b1;
    send(3'b000, 32'h0000_0001, 32'h0000_0013, 32'h0010_0013, 1'b0);
    check("flush_lat_early", {31'b0, out_valid}, 32'd0);
    tick(acc);
    check("flush_lat_valid", {31'b0, out_valid}, 32'd1);
    drain();
    check("flush_enc_after", {16'b0, enc_count}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the immediate generator: packs a 32-bit immediate into the immediate bit-fields of an RV32I instruction word.
- Input is an instruction template carrying opcode, rd, rs1, rs2, funct3 and funct7; the block overwrites the immediate fields of the selected format.
- Sits in the instruction-assembly path (boot-loader / test-program builder) ahead of instruction memory writes.
- Two-stage valid/ready pipeline that range-checks each immediate and keeps saturating statistics counters.

Parameters:
- CNT_W, 16, width of enc_count and err_count.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request this cycle.
- in_extop  in  3  format select: 000 I, 001 U, 010 S, 011 B, any other value J.
- in_imm  in  32  immediate value, byte offset for B/J.
- in_tmpl  in  32  instruction template; its immediate-field bits are ignored.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_instr  out  32  encoded instruction.
- out_err  out  1  immediate not representable in the selected format.
- enc_count  out  CNT_W  results handed off, saturating.
- err_count  out  CNT_W  results handed off with out_err=1, saturating.

Behaviour:
- Reset: clear v1, v2, out_valid, out_instr, out_err, enc_count and err_count to 0. in_ready is 1 in the cycle after reset.
- Stage 1 (register v1/d1):
  - Captures {extop, imm, tmpl} when in_valid && in_ready.
  - Computes the range check: I and S need imm[31:11] all equal; B needs imm[31:12] all equal and imm[0]=0; J needs imm[31:20] all equal and imm[0]=0; U needs imm[11:0]=0.
- Stage 2 (register v2 = out_valid):
  - Merges the immediate into the template; all template bits outside the immediate fields pass through unchanged.
  - I: [31:20]=imm[11:0].
  - U: [31:12]=imm[31:12].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  - On error the same truncated encoding is still produced, and out_err=1.
- Flow control:
  - adv2 = !v2 || out_ready.
  - adv1 = !v1 || adv2.
  - in_ready = adv1, combinational.
  - No bubbles: full throughput of 1 per cycle when out_ready is held at 1.
- Latency: 2 cycles from the accept edge to out_valid.
- out_instr and out_err stay stable while out_valid && !out_ready. In-order delivery; nothing dropped or duplicated.
- Counters:
  - enc_count increments on each out_valid && out_ready.
  - err_count increments on the same handshake when out_err=1.
  - Both saturate at all-ones.
- Reset mid-operation flushes both stages; in-flight requests are discarded and not counted.
- An in_extop of 100–111 is encoded as J; this is not an error.

Optional Feature:
- Macro: IMM_ENCODER_ROUNDTRIP_EN.
- Defined:
  - Stage 2 also decodes out_instr back to an immediate with the standard sign-extended rules.
  - A registered output rt_mismatch (1 bit) is 1 when a valid, non-error result's decoded immediate differs from the stage-1 imm.
  - rt_mismatch resets to 0 and is updated with each stage-2 load.
- Undefined: the port and the decode logic are absent.

Decomposition:
- Shared package imm_pkg holds:
  - extop constants EXT_I, EXT_U, EXT_S, EXT_B, EXT_J.
  - instruction field bit-position constants.
  - a struct/typedef for the stage-1 payload.
- Sub-module imm_field_pack: purely combinational {extop, imm, tmpl} -> {instr, err}, instantiated in stage 2.
- The round-trip decoder, when enabled, is inline logic.

Test Plan:
- I-type: tmpl=0x00000013, imm=0xFFFFFFFF, extop=000, out_ready=1 -> 2 cycles later out_instr=0xFFF00013, out_err=0, enc_count=1.
- B-type: tmpl=0x00000063, imm=0xFFFFFFFC, extop=011 -> out_instr=0xFE000EE3, out_err=0.
- U-type:
  - imm=0x12345000, tmpl=0x00000037 -> 0x12345037, err=0.
  - Next request imm=0x12345001 -> out_err=1, err_count=1.
- J misaligned: imm=0x00000003, extop=100 -> out_err=1. S-type imm=0x00000800 -> out_err=1.
- Backpressure:
  - Drive 4 back-to-back requests with out_ready=0.
  - in_ready falls after 2 accepts.
  - out_instr is held stable.
  - Raise out_ready -> all 4 results emerge in order, enc_count=4.
- Reset with both stages full -> next cycle out_valid=0, counters=0. A new request emerges after 2 cycles and the old data never appears.
